// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
//   Bundle between the VGA timing generator and the pixel/framebuffer logic.
//
//   Parameters:
//     HW : width of HCount
//     VW : width of VCount and line_cmp
//
//   Signals:
//     pix_en       sink -> gen  pixel-rate clock enable
//     line_cmp     sink -> gen  line number that raises line_irq
//     hsync        gen -> sink  horizontal sync (polarity set by the generator)
//     vsync        gen -> sink  vertical sync (polarity set by the generator)
//     active_video gen -> sink  position is inside the visible area
//     HCount       gen -> sink  current pixel column
//     VCount       gen -> sink  current line
//     line_start   gen -> sink  strobe, HCount just became 0
//     frame_start  gen -> sink  strobe, position just became (0,0)
//     line_irq     gen -> sink  strobe, position just became (0,line_cmp)
//
//   Modports:
//     master : the timing generator
//     slave  : the consumer of the timing
// -----------------------------------------------------------------------------
interface vga_timing_gen_if #(
    parameter int HW = 10,
    parameter int VW = 10
) ();

    logic          pix_en;
    logic [VW-1:0] line_cmp;
    logic          hsync;
    logic          vsync;
    logic          active_video;
    logic [HW-1:0] HCount;
    logic [VW-1:0] VCount;
    logic          line_start;
    logic          frame_start;
    logic          line_irq;

    modport master (
        input  pix_en,
        input  line_cmp,
        output hsync,
        output vsync,
        output active_video,
        output HCount,
        output VCount,
        output line_start,
        output frame_start,
        output line_irq
    );

    modport slave (
        output pix_en,
        output line_cmp,
        input  hsync,
        input  vsync,
        input  active_video,
        input  HCount,
        input  VCount,
        input  line_start,
        input  frame_start,
        input  line_irq
    );

endinterface

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised VGA/display timing generator. Walks a raster position
//   (HCount, VCount) through H_TOTAL x V_TOTAL positions at the pixel-enable
//   rate and decodes sync, visible-area and strobe signals for that position.
//
//   Every output is a flop loaded on the same edge as the counters, and the
//   decode is computed from the *next* position, so counters and decoded
//   signals always describe the same pixel (zero skew).
//
//   Ports:
//     clk  : system clock
//     rst  : synchronous reset, active-high; parks the position at the last
//            back-porch pixel so the first enabled cycle lands on (0,0)
//     bus  : vga_timing_gen_if.master (pix_en, line_cmp in; syncs, counters,
//            active_video and the three strobes out)
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int HW         = 10,
    parameter int VW         = 10
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Last position of each axis; also the reset parking position.
    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    // First column/line that is no longer visible.
    localparam logic [HW-1:0] H_VIS_END    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_VIS_END    = VW'(V_ACTIVE);
    // Inclusive sync pulse windows.
    localparam logic [HW-1:0] H_SYNC_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_SYNC_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Maps "inside the pulse window" to the configured line level.
    function automatic logic sync_level(input logic in_pulse, input logic pol);
        logic lvl;
        if (in_pulse) begin
            lvl = pol;
        end else begin
            lvl = ~pol;
        end
        return lvl;
    endfunction

    logic [HW-1:0] r_hcount;
    logic [VW-1:0] r_vcount;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_active;
    logic          r_line_start;
    logic          r_frame_start;
    logic          r_line_irq;

    logic [HW-1:0] w_h_next;
    logic [VW-1:0] w_v_next;
    logic          w_h_wrap;
    logic          w_active_next;
    logic          w_hsync_next;
    logic          w_vsync_next;
    logic          w_frame_next;
    logic          w_irq_next;

    // Next raster position for an enabled cycle.
    always_comb begin
        w_h_wrap = 1'b0;
        w_h_next = r_hcount;
        w_v_next = r_vcount;
        if (r_hcount == H_LAST) begin
            w_h_wrap = 1'b1;
            w_h_next = {HW{1'b0}};
            if (r_vcount == V_LAST) begin
                w_v_next = {VW{1'b0}};
            end else begin
                w_v_next = r_vcount + VW'(1);
            end
        end else begin
            w_h_next = r_hcount + HW'(1);
        end
    end

    // Decode of the next position, so it lands in the flops with the counters.
    // vsync depends only on w_v_next, which moves only on the line wrap.
    always_comb begin
        w_active_next = (w_h_next < H_VIS_END) && (w_v_next < V_VIS_END);
        w_hsync_next  = sync_level((w_h_next >= H_SYNC_FIRST) && (w_h_next <= H_SYNC_LAST),
                                   H_SYNC_POL);
        w_vsync_next  = sync_level((w_v_next >= V_SYNC_FIRST) && (w_v_next <= V_SYNC_LAST),
                                   V_SYNC_POL);
        w_frame_next  = w_h_wrap && (w_v_next == {VW{1'b0}});
        // A line_cmp at or beyond V_TOTAL can never equal w_v_next.
        w_irq_next    = w_h_wrap && (w_v_next == bus.line_cmp);
    end

    // Position counters, decoded levels and strobes; reset wins over pix_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcount      <= H_LAST;
            r_vcount      <= V_LAST;
            r_active      <= 1'b0;
            r_hsync       <= ~H_SYNC_POL;
            r_vsync       <= ~V_SYNC_POL;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_irq    <= 1'b0;
        end else if (bus.pix_en) begin
            r_hcount      <= w_h_next;
            r_vcount      <= w_v_next;
            r_active      <= w_active_next;
            r_hsync       <= w_hsync_next;
            r_vsync       <= w_vsync_next;
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_frame_next;
            r_line_irq    <= w_irq_next;
        end else begin
            // Position and levels hold; strobes last a single clk only.
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_irq    <= 1'b0;
        end
    end

    assign bus.HCount       = r_hcount;
    assign bus.VCount       = r_vcount;
    assign bus.hsync        = r_hsync;
    assign bus.vsync        = r_vsync;
    assign bus.active_video = r_active;
    assign bus.line_start   = r_line_start;
    assign bus.frame_start  = r_frame_start;
    assign bus.line_irq     = r_line_irq;

endmodule
